// File: rtl/mem_arb_defs_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states and request-port owner codes.
package mem_arb_defs;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_BUSY_IF = 2'd2,
        ARB_BUSY_DM = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache request port between fetch (IF) and load/store (DM), one request outstanding.
// Optional perf counters are built when MEM_PORT_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                dm_req_valid,
    output logic                dm_req_ready,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic [DATA_W-1:0]   dm_req_wdata,
    input  logic [DATA_W/8-1:0] dm_req_wmask,
    output logic                dm_resp_valid,
    output logic [DATA_W-1:0]   dm_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_dm_grants,
    output logic [31:0]         perf_conflicts,
`endif
    output logic [1:0]          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    // Handshake: a request fires when valid && ready; the requester holds valid
    // and payload stable until then, and the cache may hold ready low.

    localparam logic [STARVE_W-1:0] STARVE_V = STARVE_W'(STARVE_MAX);

    arb_state_t          state;
    arb_owner_t          owner;
    arb_owner_t          winner;
    arb_owner_t          cur_owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                fire_if;
    logic                fire_dm;

    always_comb begin
        winner = OWN_NONE;
        if (dm_req_valid && !(if_req_valid && (starve_cnt == STARVE_V))) begin
            winner = OWN_DM;
        end else if (if_req_valid) begin
            winner = OWN_IF;
        end
        // Arbitration only happens in IDLE; WAIT keeps the latched grant.
        case (state)
            ARB_IDLE: cur_owner = winner;
            ARB_WAIT: cur_owner = owner;
            default:  cur_owner = OWN_NONE;
        endcase
        if (!reset_n) begin
            cur_owner = OWN_NONE;
        end
    end

    assign mem_req_valid = (cur_owner != OWN_NONE);
    assign mem_req_addr  = (cur_owner == OWN_DM) ? dm_req_addr  : if_req_addr;
    assign mem_req_wdata = (cur_owner == OWN_DM) ? dm_req_wdata : '0;
    assign mem_req_wmask = (cur_owner == OWN_DM) ? dm_req_wmask : '0;
    assign if_req_ready  = (cur_owner == OWN_IF) && mem_req_ready;
    assign dm_req_ready  = (cur_owner == OWN_DM) && mem_req_ready;
    assign fire_if       = if_req_ready;
    assign fire_dm       = dm_req_ready;

    assign if_resp_valid = reset_n && (state == ARB_BUSY_IF) && mem_resp_valid;
    assign dm_resp_valid = reset_n && (state == ARB_BUSY_DM) && mem_resp_valid;
    assign if_resp_data  = mem_resp_data;
    assign dm_resp_data  = mem_resp_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            owner <= OWN_NONE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (winner != OWN_NONE) begin
                        owner <= winner;
                        if (mem_req_ready) begin
                            state <= (winner == OWN_IF) ? ARB_BUSY_IF : ARB_BUSY_DM;
                        end else begin
                            state <= ARB_WAIT;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (mem_req_ready) begin
                        state <= (owner == OWN_IF) ? ARB_BUSY_IF : ARB_BUSY_DM;
                    end
                end
                default: begin
                    // Any response in IDLE/WAIT is spurious and never reaches here.
                    if (mem_resp_valid) begin
                        state <= ARB_IDLE;
                        owner <= OWN_NONE;
                    end
                end
            endcase
        end
    end

    arb_sat_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fire_if),
        .inc     (fire_dm && if_req_valid),
        .count   (starve_cnt)
    );

`ifdef MEM_PORT_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_if_grants <= '0;
            perf_dm_grants <= '0;
            perf_conflicts <= '0;
        end else begin
            if (fire_if) perf_if_grants <= perf_if_grants + 32'd1;
            if (fire_dm) perf_dm_grants <= perf_dm_grants + 32'd1;
            if ((state == ARB_IDLE) && if_req_valid && dm_req_valid) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule
